// File: rtl/cotm32_pkg.sv
// Shared definitions for the cotm32 peripherals: bus widths, the UART RX
// register map, control/status bit positions and the receiver state type.
package cotm32_pkg;

  localparam int XLEN             = 32;
  localparam int UART_RX_MEM_SIZE = 16;
  localparam int UART_RX_AW       = $clog2(UART_RX_MEM_SIZE);

  localparam logic [UART_RX_AW-1:0] UART_RX_RXDATA = 4'h0;
  localparam logic [UART_RX_AW-1:0] UART_RX_STATUS = 4'h4;
  localparam logic [UART_RX_AW-1:0] UART_RX_CTRL   = 4'h8;
  localparam logic [UART_RX_AW-1:0] UART_RX_DIV    = 4'hC;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_RXIE_BIT    = 1;
  localparam int CTRL_ERRIE_BIT   = 2;
  localparam int STATUS_OVR_BIT   = 0;
  localparam int STATUS_FERR_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 8;

  localparam logic [15:0] UART_RX_MIN_DIV = 16'd4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with a combinational head read. A push into a full FIFO
// is only accepted when a pop retires the head in the same cycle.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (count_reg == (AW+1)'(DEPTH));
  assign o_empty = (count_reg == '0);
  assign o_count = count_reg;
  assign o_rdata = mem[rd_ptr_reg];

  assign do_pop  = i_pop & ~o_empty;
  // When full, the popped slot is the one the write pointer targets.
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver: synchronised line, mid-bit sampling FSM,
// byte FIFO, sticky OVR/FERR flags and a level interrupt.
module uart_rx
  import cotm32_pkg::*;
#(
  parameter int          RX_FIFO_DEPTH = 8,
  parameter logic [15:0] DEFAULT_DIV   = 16'd16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  input  logic                  i_re,
  input  logic                  i_we,
  input  logic [UART_RX_AW-1:0] i_addr,
  input  logic [XLEN-1:0]       i_wdata,
  output logic [XLEN-1:0]       o_rdata,
  output logic                  o_irq
);

  localparam int CNT_W = $clog2(RX_FIFO_DEPTH) + 1;

  logic [1:0]     sync_reg;
  logic           rx_line;
  uart_rx_state_e state_reg, state_next;
  logic [15:0]    div_q_reg, div_q_next;
  logic [15:0]    cyc_cnt_reg, cyc_cnt_next;
  logic [2:0]     bit_cnt_reg, bit_cnt_next;
  logic [7:0]     shift_reg, shift_next;
  logic [15:0]    half_div;
  logic           frame_done;
  logic           ferr_set;

  logic [2:0]     ctrl_reg;
  logic [15:0]    div_reg;
  logic           ovr_reg;
  logic           ferr_reg;
  logic           ovr_set;

  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_head;
  logic [CNT_W-1:0] fifo_count;

  logic           ctrl_we;
  logic           div_we;
  logic           status_we;
  logic           unused_wdata;

  assign rx_line   = sync_reg[1];
  assign ctrl_we   = i_we & (i_addr == UART_RX_CTRL);
  assign div_we    = i_we & (i_addr == UART_RX_DIV);
  assign status_we = i_we & (i_addr == UART_RX_STATUS);
  assign fifo_pop  = i_re & (i_addr == UART_RX_RXDATA);
  assign unused_wdata = ^i_wdata[XLEN-1:16];

  // A full FIFO still accepts the byte when the core pops in the same cycle.
  assign fifo_push = frame_done & (~fifo_full | (fifo_pop & ~fifo_empty));
  assign ovr_set   = frame_done & fifo_full & ~(fifo_pop & ~fifo_empty);

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_wdata (shift_reg),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_reg    <= 2'b11;
      state_reg   <= IDLE;
      div_q_reg   <= DEFAULT_DIV;
      cyc_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else begin
      sync_reg    <= {sync_reg[0], i_rx};
      state_reg   <= state_next;
      div_q_reg   <= div_q_next;
      cyc_cnt_reg <= cyc_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    div_q_next   = div_q_reg;
    cyc_cnt_next = cyc_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    frame_done   = 1'b0;
    ferr_set     = 1'b0;
    half_div     = {1'b0, div_q_reg[15:1]};
    if (state_reg != IDLE && !ctrl_reg[CTRL_EN_BIT]) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ctrl_reg[CTRL_EN_BIT] && !rx_line) begin
            div_q_next   = div_reg;
            cyc_cnt_next = '0;
            bit_cnt_next = '0;
            state_next   = START;
          end
        end
        START: begin
          if (cyc_cnt_reg == half_div - 16'd1) begin
            cyc_cnt_next = '0;
            state_next   = rx_line ? IDLE : DATA;
          end else begin
            cyc_cnt_next = cyc_cnt_reg + 16'd1;
          end
        end
        DATA: begin
          if (cyc_cnt_reg == div_q_reg - 16'd1) begin
            cyc_cnt_next = '0;
            shift_next   = {rx_line, shift_reg[7:1]};
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_next = STOP;
            end
          end else begin
            cyc_cnt_next = cyc_cnt_reg + 16'd1;
          end
        end
        STOP: begin
          if (cyc_cnt_reg == div_q_reg - 16'd1) begin
            cyc_cnt_next = '0;
            if (rx_line) begin
              frame_done = 1'b1;
              state_next = IDLE;
            end else begin
              ferr_set   = 1'b1;
              state_next = WAIT_IDLE;
            end
          end else begin
            cyc_cnt_next = cyc_cnt_reg + 16'd1;
          end
        end
        WAIT_IDLE: begin
          if (rx_line) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl_reg <= '0;
      div_reg  <= DEFAULT_DIV;
      ovr_reg  <= 1'b0;
      ferr_reg <= 1'b0;
    end else begin
      if (ctrl_we) begin
        ctrl_reg <= i_wdata[2:0];
      end
      if (div_we) begin
        div_reg <= (i_wdata[15:0] < UART_RX_MIN_DIV) ? UART_RX_MIN_DIV : i_wdata[15:0];
      end
      // Hardware set wins over a write-one-to-clear in the same cycle.
      ovr_reg  <= ovr_set  | (ovr_reg  & ~(status_we & i_wdata[STATUS_OVR_BIT]));
      ferr_reg <= ferr_set | (ferr_reg & ~(status_we & i_wdata[STATUS_FERR_BIT]));
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      UART_RX_RXDATA: begin
        if (fifo_empty) begin
          o_rdata[XLEN-1] = 1'b1;
        end else begin
          o_rdata[7:0] = fifo_head;
        end
      end
      UART_RX_STATUS: begin
        o_rdata[STATUS_COUNT_LSB +: CNT_W] = fifo_count;
        o_rdata[STATUS_FERR_BIT]           = ferr_reg;
        o_rdata[STATUS_OVR_BIT]            = ovr_reg;
      end
      UART_RX_CTRL: o_rdata[2:0]  = ctrl_reg;
      UART_RX_DIV:  o_rdata[15:0] = div_reg;
      default:      o_rdata = '0;
    endcase
  end

  assign o_irq = (ctrl_reg[CTRL_RXIE_BIT] & ~fifo_empty)
               | (ctrl_reg[CTRL_ERRIE_BIT] & (ovr_reg | ferr_reg));

endmodule

// File: tb/tb_uart_rx.sv
// Directed-sequence bench for uart_rx with random payloads and divisors,
// checked against a queue-based model of the receive FIFO and sticky flags.
module tb_uart_rx;
  import cotm32_pkg::*;

  localparam int DEPTH = 8;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        rx    = 1'b1;
  logic        re    = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  addr  = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  byte unsigned exp_q[$];
  bit          ovr_m  = 1'b0;
  bit          ferr_m = 1'b0;

  uart_rx #(
    .RX_FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV   (16'd16)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_rx    (rx),
    .i_re    (re),
    .i_we    (we),
    .i_addr  (addr),
    .i_wdata (wdata),
    .o_rdata (rdata),
    .o_irq   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_status();
    return (32'(exp_q.size()) << 8) | {30'b0, ferr_m, ovr_m};
  endfunction

  function automatic logic [31:0] exp_rxdata();
    return (exp_q.size() == 0) ? 32'h8000_0000 : {24'b0, exp_q[0]};
  endfunction

  task automatic model_push(input byte unsigned b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else ovr_m = 1'b1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    re = 1'b0; addr = a;
    #1 d = rdata;
  endtask

  // Reads RXDATA with a pop strobe and compares against the model head.
  task automatic read_expect(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    @(negedge clk);
    addr = UART_RX_RXDATA; re = 1'b1;
    #1 d = rdata;
    e = exp_rxdata();
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    re = 1'b0;
    check(tag, d, e);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    peek(UART_RX_STATUS, d);
    check(tag, d, exp_status());
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame (or its first ncyc cycles), peeking STATUS every cycle.
  // seen_at = first cycle the FIFO count differs from its value at cycle 0;
  // pop_at >= 0 raises a single-cycle RXDATA pop at that cycle.
  task automatic send_frame(input byte unsigned b, input bit stop, input int div,
                            input int ncyc, input int pop_at, output int seen_at);
    logic [9:0]  bits;
    logic [31:0] st;
    int          base;
    int          limit;
    bits    = {stop, b, 1'b0};
    limit   = (ncyc < 0) ? 10 * div : ncyc;
    seen_at = -1;
    base    = 0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      re = 1'b0; addr = UART_RX_STATUS;
      #1 st = rdata;
      if (c == 0) base = int'(st[15:8]);
      else if (seen_at < 0 && int'(st[15:8]) != base) seen_at = c;
      if (c == pop_at) begin
        addr = UART_RX_RXDATA; re = 1'b1;
      end
      rx = bits[c / div];
    end
    @(negedge clk);
    re = 1'b0;
  endtask

  initial begin
    logic [31:0]  d;
    int           lat;
    int           dummy;
    int           rdiv;
    int           nominal;
    byte unsigned b;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    peek(UART_RX_STATUS, d); check("rst_status", d, 32'h0);
    peek(UART_RX_RXDATA, d); check("rst_rxdata", d, 32'h8000_0000);
    peek(UART_RX_CTRL, d);   check("rst_ctrl", d, 32'h0);
    peek(UART_RX_DIV, d);    check("rst_div", d, 32'd16);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // Basic receive and push latency at DIV=16
    bus_write(UART_RX_CTRL, 32'h1);
    send_frame(8'h55, 1'b1, 16, -1, -1, lat);
    model_push(8'h55);
    nominal = 2 + 8 + 9 * 16;
    check("latency_ok", {31'b0, (lat >= nominal - 1 && lat <= nominal + 2)}, 32'h1);
    idle(4);
    check_status("status_1");
    read_expect("read_55");
    read_expect("read_empty");

    // Overrun: one more frame than the FIFO holds
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 16, -1, -1, dummy);
      model_push(b);
      idle(2);
    end
    check_status("ovr_status");
    bus_write(UART_RX_STATUS, 32'h1);
    ovr_m = 1'b0;
    check_status("ovr_w1c");

    // Push and pop in the same cycle while full
    b = 8'($urandom);
    send_frame(b, 1'b1, 16, -1, (lat > 0) ? lat - 1 : nominal, dummy);
    void'(exp_q.pop_front());
    exp_q.push_back(b);
    idle(4);
    check_status("full_pushpop");
    for (int i = 0; i < DEPTH + 1; i++) read_expect("drain");

    // Frame error with line held low, then recovery
    send_frame(8'hA5, 1'b0, 16, -1, -1, dummy);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    ferr_m = 1'b1;
    check_status("ferr_status");
    idle(5);
    b = 8'($urandom);
    send_frame(b, 1'b1, 16, -1, -1, dummy);
    model_push(b);
    idle(4);
    read_expect("after_ferr");
    bus_write(UART_RX_STATUS, 32'h2);
    ferr_m = 1'b0;
    check_status("ferr_w1c");

    // Short glitch produces nothing
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(200);
    check_status("glitch");

    // DIV clamp and a random divisor
    bus_write(UART_RX_DIV, 32'h1);
    peek(UART_RX_DIV, d); check("div_clamp", d, 32'd4);
    b = 8'($urandom);
    send_frame(b, 1'b1, 4, -1, -1, dummy);
    model_push(b);
    idle(6);
    read_expect("div4_byte");
    rdiv = 5 + int'($urandom_range(0, 15));
    bus_write(UART_RX_DIV, 32'(rdiv));
    peek(UART_RX_DIV, d); check("div_rand", d, 32'(rdiv));
    b = 8'($urandom);
    send_frame(b, 1'b1, rdiv, -1, -1, dummy);
    model_push(b);
    idle(rdiv + 4);
    read_expect("divr_byte");
    bus_write(UART_RX_DIV, 32'd16);

    // Interrupts
    bus_write(UART_RX_CTRL, 32'h3);
    check("irq_idle", {31'b0, irq}, 32'h0);
    b = 8'($urandom);
    send_frame(b, 1'b1, 16, -1, -1, dummy);
    model_push(b);
    idle(2);
    check("irq_rx", {31'b0, irq}, 32'h1);
    read_expect("irq_byte");
    check("irq_drained", {31'b0, irq}, 32'h0);
    bus_write(UART_RX_CTRL, 32'h5);
    send_frame(8'h00, 1'b0, 16, -1, -1, dummy);
    ferr_m = 1'b1;
    idle(4);
    check("irq_err", {31'b0, irq}, 32'h1);
    bus_write(UART_RX_STATUS, 32'h2);
    ferr_m = 1'b0;
    check("irq_err_clr", {31'b0, irq}, 32'h0);

    // Disable mid-frame keeps FIFO contents
    bus_write(UART_RX_CTRL, 32'h1);
    b = 8'($urandom);
    send_frame(b, 1'b1, 16, -1, -1, dummy);
    model_push(b);
    idle(4);
    send_frame(8'($urandom), 1'b1, 16, 88, -1, dummy);
    bus_write(UART_RX_CTRL, 32'h0);
    idle(200);
    check_status("en_clear");

    // Reset during data bit 4
    bus_write(UART_RX_CTRL, 32'h1);
    send_frame(8'($urandom), 1'b1, 16, 88, -1, dummy);
    @(negedge clk);
    rst = 1'b1; rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    ovr_m = 1'b0; ferr_m = 1'b0;
    check("mrst_irq", {31'b0, irq}, 32'h0);
    check_status("mrst_status");
    peek(UART_RX_CTRL, d);   check("mrst_ctrl", d, 32'h0);
    peek(UART_RX_RXDATA, d); check("mrst_rxdata", d, 32'h8000_0000);
    idle(200);
    check_status("mrst_nopush");
    bus_write(UART_RX_CTRL, 32'h1);
    b = 8'($urandom);
    send_frame(b, 1'b1, 16, -1, -1, dummy);
    model_push(b);
    idle(4);
    read_expect("post_rst");
    read_expect("post_rst_mt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
